oai_lane_pipe: RTL and testbench

OAI_LANE_PIPE -- requirements
Module: oai_lane_pipe

---
 rtl/oai_lane_pipe_pkg.sv | 51 +++++
 rtl/oai_lane_pipe_stage.sv | 35 +++
 rtl/oai_lane_pipe.sv | 120 ++++++++++++
 tb/tb_oai_lane_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/oai_lane_pipe_pkg.sv
// Shared types and the per-lane logic evaluation for the OAI/AOI lane pipeline.
package oai_lane_pipe_pkg;

  // Widest A or B group a lane may have; narrower groups are padded up to this.
  localparam int MAX_GROUP = 8;

  // Evaluation mode carried with every beat.
  typedef enum logic {
    MODE_OAI = 1'b0,
    MODE_AOI = 1'b1
  } mode_e;

  // Evaluate one lane. Only the low na bits of a and the low nb bits of b
  // take part; the padding bits above them are ignored.
  //   MODE_OAI : NOT((OR a) AND (OR b))
  //   MODE_AOI : NOT((AND a) OR (AND b))
  function automatic logic lane_eval(
    input mode_e                mode,
    input logic [MAX_GROUP-1:0] a,
    input int                   na,
    input logic [MAX_GROUP-1:0] b,
    input int                   nb
  );
    logic a_or;
    logic a_and;
    logic b_or;
    logic b_and;
    logic result;
    a_or  = 1'b0;
    a_and = 1'b1;
    b_or  = 1'b0;
    b_and = 1'b1;
    for (int i = 0; i < MAX_GROUP; i++) begin
      if (i < na) begin
        a_or  = a_or  | a[i];
        a_and = a_and & a[i];
      end
      if (i < nb) begin
        b_or  = b_or  | b[i];
        b_and = b_and & b[i];
      end
    end
    if (mode == MODE_AOI) begin
      result = ~(a_and | b_and);
    end else begin
      result = ~(a_or & b_or);
    end
    return result;
  endfunction

endpackage

// File: rtl/oai_lane_pipe_stage.sv
// One pipeline stage: a valid bit plus a W-bit payload, updated on load.
// The payload only changes when a valid beat is loaded, so a stage that
// drains keeps showing its last result rather than a meaningless value.
module oai_lane_pipe_stage
  import oai_lane_pipe_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         d_valid,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // Stage register: synchronous reset, then load-enabled capture.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      // NOTE: the payload is reset too, not just valid, because the output
      // stage payload is visible on ZN and must read zero after reset.
      q     <= '0;
    end else if (load) begin
      valid <= d_valid;
      if (d_valid) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/oai_lane_pipe.sv
// Two-stage valid/ready pipeline evaluating LANES independent OAI/AOI gates.
// S1 captures the raw operands and mode; S2 holds the registered result.
// IN_READY depends only on state and OUT_READY, never on IN_VALID, and there
// is no combinational path from A, B or MODE to ZN.
module oai_lane_pipe
  import oai_lane_pipe_pkg::*;
#(
  parameter int LANES = 4,
  parameter int NA    = 3,   // 1..MAX_GROUP
  parameter int NB    = 2,   // 1..MAX_GROUP
  parameter int CW    = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic                MODE,
  input  logic [LANES*NA-1:0] A,
  input  logic [LANES*NB-1:0] B,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [LANES-1:0]    ZN,
  output logic [CW-1:0]       CNT,
  inout  wire                 VDD,
  inout  wire                 VSS
);

  localparam int AW   = LANES * NA;
  localparam int BW   = LANES * NB;
  localparam int S1_W = AW + BW + 1;

  // Supply pins carry no function; they are only sunk here.
  logic unused_supply;
  assign unused_supply = VDD ^ VSS;

  // Stage S1: operands and mode of the oldest not-yet-evaluated beat.
  logic            s1_valid;
  logic [S1_W-1:0] s1_data;
  logic [AW-1:0]   s1_a;
  logic [BW-1:0]   s1_b;
  mode_e           s1_mode;

  // Stage S2: registered per-lane result.
  logic             s2_valid;
  logic [LANES-1:0] s2_data;

  // Handshake and datapath nets.
  logic             s2_load;
  logic [LANES-1:0] zn_next;
  logic [CW-1:0]    cnt_q;

  // S2 can take a new value whenever it is empty or its beat leaves this cycle.
  assign s2_load = ~s2_valid | OUT_READY;

  // S1 can take a beat if it is empty or its beat moves into S2. Reset forces
  // ready high; the stage itself gives reset priority, so nothing is captured.
  assign IN_READY = RST | ~s1_valid | s2_load;

  oai_lane_pipe_stage #(
    .W (S1_W)
  ) u_s1 (
    .clk     (CLK),
    .rst     (RST),
    .load    (IN_READY),
    .d_valid (IN_VALID),
    .d       ({MODE, B, A}),
    .valid   (s1_valid),
    .q       (s1_data)
  );

  assign s1_a    = s1_data[AW-1:0];
  assign s1_b    = s1_data[AW +: BW];
  assign s1_mode = mode_e'(s1_data[S1_W-1]);

  // Per-lane evaluation of the S1 beat; each lane's group is padded to the
  // package-wide width and the real group size is passed alongside.
  // NOTE: every variable is given a default at the top of the block so no
  // path leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    logic [MAX_GROUP-1:0] a_pad;
    logic [MAX_GROUP-1:0] b_pad;
    zn_next = '0;
    a_pad   = '0;
    b_pad   = '0;
    for (int i = 0; i < LANES; i++) begin
      a_pad         = '0;
      b_pad         = '0;
      a_pad[NA-1:0] = s1_a[i*NA +: NA];
      b_pad[NB-1:0] = s1_b[i*NB +: NB];
      zn_next[i]    = lane_eval(s1_mode, a_pad, NA, b_pad, NB);
    end
  end

  oai_lane_pipe_stage #(
    .W (LANES)
  ) u_s2 (
    .clk     (CLK),
    .rst     (RST),
    .load    (s2_load),
    .d_valid (s1_valid),
    .d       (zn_next),
    .valid   (s2_valid),
    .q       (s2_data)
  );

  assign OUT_VALID = s2_valid;
  assign ZN        = s2_data;

  // Completed-transfer counter, wrapping naturally at 2^CW.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (s2_valid && OUT_READY) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign CNT = cnt_q;

endmodule

// File: tb/tb_oai_lane_pipe.sv
// Bench for oai_lane_pipe (LANES=2, NA=3, NB=2, CW=4): directed scenarios
// followed by random traffic, all compared against an in-order beat queue.
module tb_oai_lane_pipe;

  localparam int LANES = 2;
  localparam int NA    = 3;
  localparam int NB    = 2;
  localparam int CW    = 4;
  localparam int AW    = LANES * NA;
  localparam int BW    = LANES * NB;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [AW-1:0]    a;
  logic [BW-1:0]    b;
  logic             out_valid;
  logic             out_ready;
  logic [LANES-1:0] zn;
  logic [CW-1:0]    cnt;
  wire              vdd = 1'b1;
  wire              vss = 1'b0;

  oai_lane_pipe #(
    .LANES (LANES),
    .NA    (NA),
    .NB    (NB),
    .CW    (CW)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .MODE      (mode),
    .A         (a),
    .B         (b),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .ZN        (zn),
    .CNT       (cnt),
    .VDD       (vdd),
    .VSS       (vss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: beats in flight, oldest first. age counts rising edges
  // since acceptance; a beat is visible at the output once age >= 1.
  typedef struct {
    logic [LANES-1:0] zn;
    int               age;
  } beat_t;

  beat_t q[$];
  int    exp_cnt;
  int    checks;
  int    errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Gate truth from the functional definition, using reduction operators.
  function automatic logic [LANES-1:0] model_zn(input logic m, input logic [AW-1:0] av,
                                                input logic [BW-1:0] bv);
    logic [LANES-1:0] r;
    logic [NA-1:0]    al;
    logic [NB-1:0]    bl;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      al = av[i*NA +: NA];
      bl = bv[i*NB +: NB];
      if (m) r[i] = !((&al) || (&bl));
      else   r[i] = !((|al) && (|bl));
    end
    return r;
  endfunction

  // One clock: check outputs at the falling edge against the model, then
  // advance the model across the rising edge. Returns 1 time unit after it.
  task automatic step();
    logic exp_ready;
    logic exp_valid;
    logic acc;
    logic xfr;
    @(negedge clk);
    exp_ready = rst || !(q.size() == 2 && !out_ready);
    exp_valid = (q.size() > 0) && (q[0].age >= 1);
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, exp_valid);
    if (exp_valid) check("zn_order", zn, q[0].zn);
    check("cnt", cnt, exp_cnt);
    acc = in_valid && exp_ready && !rst;
    xfr = exp_valid && out_ready && !rst;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      exp_cnt = 0;
    end else begin
      if (xfr) begin
        void'(q.pop_front());
        exp_cnt = (exp_cnt + 1) % (1 << CW);
      end
      foreach (q[i]) q[i].age++;
      if (acc) q.push_back('{zn: model_zn(mode, a, b), age: 0});
    end
  endtask

  task automatic rand_operands();
    a    = AW'($urandom);
    b    = BW'($urandom);
    mode = 1'($urandom);
  endtask

  logic [LANES-1:0] zn_hold;

  initial begin
    checks    = 0;
    errors    = 0;
    exp_cnt   = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    mode      = 1'b0;
    a         = '0;
    b         = '0;

    // Reset for two cycles with a beat offered.
    @(posedge clk);
    #1;
    step();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_zn", zn, 2'b00);
    check("rst_cnt", cnt, 4'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    check("rst_nothing_accepted", out_valid, 1'b0);

    // OAI beat.
    a = 6'b100_000; b = 4'b01_11; mode = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("oai_latency_k", out_valid, 1'b0);
    step();
    check("oai_valid_k1", out_valid, 1'b1);
    check("oai_zn", zn, 2'b01);
    step();
    check("oai_cnt", cnt, 4'd1);

    // AOI beat.
    a = 6'b011_111; b = 4'b10_00; mode = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("aoi_valid", out_valid, 1'b1);
    check("aoi_zn", zn, 2'b10);
    step();
    check("aoi_cnt", cnt, 4'd2);

    // Backpressure: three beats offered while the consumer stalls.
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    rand_operands();
    step();
    rand_operands();
    step();
    rand_operands();
    check("bp_full_not_ready", in_ready, 1'b0);
    zn_hold = zn;
    step();
    check("bp_zn_stable", zn, zn_hold);
    check("bp_valid_held", out_valid, 1'b1);
    step();
    check("bp_zn_stable2", zn, zn_hold);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check("bp_cnt", cnt, 4'd3);

    // Streaming 17 beats back to back; CNT wraps to 1.
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    repeat (17) begin
      rand_operands();
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();
    check("stream_cnt_wrap", cnt, 4'd1);

    // Reset with two beats in flight: they must never appear.
    out_ready = 1'b0; in_valid = 1'b1;
    rand_operands();
    step();
    rand_operands();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      step();
      check("mid_rst_no_out", out_valid, 1'b0);
    end
    check("mid_rst_cnt", cnt, 4'd0);

    // Random traffic with occasional resets.
    repeat (400) begin
      rst       = ($urandom_range(0, 59) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rand_operands();
      step();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    check("drain_empty", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
